// File: rtl/moving_avg_filter.sv
// moving_avg_filter: mean of the last 2^DEPTH_LOG2 accepted samples; MOVING_AVG_ROUND_EN selects round-half-up with saturation.
// Latency: one cycle from an accepted sample to y/y_valid; throughput one sample per clock.
// Backpressure: none; x_valid qualifies the stream and clear drops any coincident sample.
module moving_avg_filter #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              x_valid,
    input  logic [DATA_W-1:0] x,
    output logic              y_valid,
    output logic [DATA_W-1:0] y,
    output logic              filled
);
    localparam int N  = 1 << DEPTH_LOG2;
    localparam int SW = DATA_W + DEPTH_LOG2;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [DEPTH_LOG2:0] CNT_LAST = (DEPTH_LOG2 + 1)'(N - 1);

    logic [DATA_W-1:0]     mem [N];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   cnt;
    logic [SW-1:0]         sum;
    logic [SW-1:0]         sum_next;
    logic [0:0]            state;
    logic [0:0]            state_next;
    logic                  accept;
    logic [DATA_W-1:0]     old;
    logic [DATA_W-1:0]     y_next;

    assign accept = x_valid & ~clear;

    // During warm-up the slot being overwritten holds stale data, so it contributes nothing.
    assign old        = (state == ST_RUN) ? mem[wr_ptr] : '0;
    assign sum_next   = sum + SW'(x) - SW'(old);
    assign state_next = ((state == ST_RUN) || (cnt == CNT_LAST)) ? ST_RUN : ST_FILL;

`ifdef MOVING_AVG_ROUND_EN
    localparam logic [SW:0] HALF = (SW + 1)'(1) << (DEPTH_LOG2 - 1);
    localparam logic [SW:0] YMAX = (SW + 1)'({DATA_W{1'b1}});

    logic [SW:0] rnd_shr;

    assign rnd_shr = ({1'b0, sum_next} + HALF) >> DEPTH_LOG2;
    assign y_next  = (rnd_shr > YMAX) ? {DATA_W{1'b1}} : DATA_W'(rnd_shr);
`else
    assign y_next = DATA_W'(sum_next >> DEPTH_LOG2);
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= x;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum     <= '0;
            cnt     <= '0;
            wr_ptr  <= '0;
            state   <= ST_FILL;
            y       <= '0;
            y_valid <= 1'b0;
        end else if (clear) begin
            sum     <= '0;
            cnt     <= '0;
            wr_ptr  <= '0;
            state   <= ST_FILL;
            y_valid <= 1'b0;
        end else if (accept) begin
            sum    <= sum_next;
            wr_ptr <= wr_ptr + 1'b1;
            state  <= state_next;
            if (state == ST_FILL) begin
                cnt <= cnt + 1'b1;
            end
            y_valid <= (state_next == ST_RUN);
            if (state_next == ST_RUN) begin
                y <= y_next;
            end
        end else begin
            y_valid <= 1'b0;
        end
    end

    assign filled = (state == ST_RUN);

endmodule

// File: tb/tb_moving_avg_filter.sv
// Bench for moving_avg_filter: directed vectors, expected means queued at issue and checked by a monitor.
// Two instances: N=4 for the main sequence, N=8 for the long warm-up after an asynchronous reset.
module tb_moving_avg_filter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_a, vld_a, clr_b, vld_b;
    logic [7:0] x_a, x_b;
    logic       yv_a, yv_b, fl_a, fl_b;
    logic [7:0] y_a, y_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always #5 clk = ~clk;

    moving_avg_filter #(.DATA_W(8), .DEPTH_LOG2(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clr_a), .x_valid(vld_a), .x(x_a),
        .y_valid(yv_a), .y(y_a), .filled(fl_a)
    );

    moving_avg_filter #(.DATA_W(8), .DEPTH_LOG2(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clr_b), .x_valid(vld_b), .x(x_b),
        .y_valid(yv_b), .y(y_b), .filled(fl_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every y_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (yv_a === 1'b1) begin
            if (qa.size() == 0) check("a_unexpected_y_valid", 32'd1, 32'd0);
            else check("a_y", {24'd0, y_a}, {24'd0, qa.pop_front()});
        end
        if (yv_b === 1'b1) begin
            if (qb.size() == 0) check("b_unexpected_y_valid", 32'd1, 32'd0);
            else check("b_y", {24'd0, y_b}, {24'd0, qb.pop_front()});
        end
    end

    // Drive one cycle of stimulus on the selected instance, then return at the
    // following negedge with that cycle's result visible.
    task automatic step(input bit sel_b, input logic clr, input logic v, input logic [7:0] d,
                        input bit push, input logic [7:0] e);
        clr_a = 1'b0; vld_a = 1'b0; x_a = 8'd0;
        clr_b = 1'b0; vld_b = 1'b0; x_b = 8'd0;
        if (sel_b) begin
            clr_b = clr; vld_b = v; x_b = d;
            if (push) qb.push_back(e);
        end else begin
            clr_a = clr; vld_a = v; x_a = d;
            if (push) qa.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic send_a(input logic [7:0] d, input logic [7:0] e_trunc, input logic [7:0] e_round);
`ifdef MOVING_AVG_ROUND_EN
        step(1'b0, 1'b0, 1'b1, d, 1'b1, e_round);
`else
        step(1'b0, 1'b0, 1'b1, d, 1'b1, e_trunc);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clr_a = 1'b0; vld_a = 1'b0; x_a = 8'd0;
        clr_b = 1'b0; vld_b = 1'b0; x_b = 8'd0;
        @(negedge clk);
        check("reset_y", {24'd0, y_a}, 32'd0);
        check("reset_y_valid", {31'd0, yv_a}, 32'd0);
        check("reset_filled", {31'd0, fl_a}, 32'd0);
        check("reset_filled_b", {31'd0, fl_b}, 32'd0);
        rst_n = 1'b1;

        // Warm-up with 0xFC: nothing until the 4th sample.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'hFC, 1'b0, 8'd0);
        check("fill3_y_valid", {31'd0, yv_a}, 32'd0);
        check("fill3_filled", {31'd0, fl_a}, 32'd0);
        send_a(8'hFC, 8'hFC, 8'hFC);
        check("fill4_y_valid", {31'd0, yv_a}, 32'd1);
        check("fill4_filled", {31'd0, fl_a}, 32'd1);

        // Fresh window 1,2,3,4 then 8.
        step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
        check("clear_filled", {31'd0, fl_a}, 32'd0);
        for (int i = 1; i <= 3; i++) step(1'b0, 1'b0, 1'b1, 8'(i), 1'b0, 8'd0);
        send_a(8'd4, 8'd2, 8'd3);
        send_a(8'd8, 8'd4, 8'd4);

        // Ramp to full scale, then back to zero.
        send_a(8'd255, 8'd67, 8'd68);
        send_a(8'd255, 8'd130, 8'd131);
        send_a(8'd255, 8'd193, 8'd193);
        send_a(8'd255, 8'd255, 8'd255);
        send_a(8'd0, 8'd191, 8'd191);
        send_a(8'd0, 8'd127, 8'd128);
        send_a(8'd0, 8'd63, 8'd64);
        send_a(8'd0, 8'd0, 8'd0);

        // Gaps in x_valid: y_valid drops, y holds, window counts samples only.
        send_a(8'd20, 8'd5, 8'd5);
        send_a(8'd40, 8'd15, 8'd15);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'd77, 1'b0, 8'd0);
            check("gap_y_valid", {31'd0, yv_a}, 32'd0);
            check("gap_y_hold", {24'd0, y_a}, 32'd15);
        end
        send_a(8'd5, 8'd16, 8'd16);

        // clear beats a coincident sample.
        step(1'b0, 1'b1, 1'b1, 8'd99, 1'b0, 8'd0);
        check("clr_filled", {31'd0, fl_a}, 32'd0);
        check("clr_y_valid", {31'd0, yv_a}, 32'd0);
        check("clr_y_hold", {24'd0, y_a}, 32'd16);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'd10, 1'b0, 8'd0);
        check("refill3_y_valid", {31'd0, yv_a}, 32'd0);
        check("refill3_y_hold", {24'd0, y_a}, 32'd16);
        send_a(8'd10, 8'd10, 8'd10);
        check("refill4_filled", {31'd0, fl_a}, 32'd1);

        // Asynchronous reset between edges while in RUN.
        #2 rst_n = 1'b0;
        #1;
        check("arst_y", {24'd0, y_a}, 32'd0);
        check("arst_y_valid", {31'd0, yv_a}, 32'd0);
        check("arst_filled", {31'd0, fl_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // N=8 warm-up: 8,16,...,64 -> mean 36.
        for (int i = 1; i <= 7; i++) step(1'b1, 1'b0, 1'b1, 8'(8 * i), 1'b0, 8'd0);
        check("b_fill7_y_valid", {31'd0, yv_b}, 32'd0);
        check("b_fill7_filled", {31'd0, fl_b}, 32'd0);
        step(1'b1, 1'b0, 1'b1, 8'd64, 1'b1, 8'd36);
        check("b_fill8_filled", {31'd0, fl_b}, 32'd1);
        check("b_fill8_y_valid", {31'd0, yv_b}, 32'd1);
        step(1'b1, 1'b0, 1'b1, 8'd72, 1'b1, 8'd44);

        step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
        check("a_queue_drained", qa.size(), 32'd0);
        check("b_queue_drained", qb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
